sd_cmd_sequencer: RTL and testbench
===================================

Name: sd_cmd_sequencer

Overview:
Command-level controller for the SD command path. It accepts one command request (index, argument, response expected) at a time and launches it through the command transmitter with a one-cycle send strobe. It tracks transmission through the transmitter's busy flag, then captures the card's 48-bit response from the CMD line or flags a timeout or format error. It enforces the inter-command gap before it accepts the next request. It sits between the init/data control FSMs and the command transmit path.

Parameters:
NCR_MAX, 64, max sd_clk cycles after transmission end with no response start bit before timeout
NCC_MIN, 8, idle sd_clk cycles enforced after each command completes
TX_START_MAX, 255, max cycles from send strobe to transmitter busy rise before tx error

Ports:
sd_clk  input  1  SD clock; all state changes on rising edge
reset  input  1  asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready
req_index  input  6  command index
req_arg  input  32  command argument
req_resp  input  1  1 = 48-bit response expected
send_en  output  1  one-cycle strobe to the transmitter
cmd_content  output  38  {index, arg} to the transmitter
sending  input  1  transmitter busy
sd_cmd_in  input  1  sampled CMD line (pulled high when idle)
done  output  1  one-cycle pulse: command finished
resp_valid  output  1  resp_data holds a well-formed response
resp_data  output  48  captured response, bit 47 first on the line
err_timeout  output  1  no response start within NCR_MAX
err_format  output  1  response transmission bit != 0 or end bit != 1
err_tx  output  1  transmitter never went busy

Behaviour:
- Reset is asynchronous. Reset values: state IDLE, req_ready=1, send_en=0, cmd_content=0, done=0, resp_valid=0, resp_data=0, all err_* = 0, counters=0.
- req_ready=1 only in IDLE.
- Accept cycle: latch {req_index, req_arg} into cmd_content and latch req_resp. Clear resp_valid and all err_*. Go to LAUNCH. cmd_content holds stable until the next accept.
- LAUNCH: send_en=1 for exactly this cycle. Go to WAIT_TX_START.
- WAIT_TX_START: sending=1 -> WAIT_TX_END. Otherwise the counter increments. When the counter reaches TX_START_MAX: set err_tx, go to GAP.
- WAIT_TX_END: sending=0 -> WAIT_RESP if the latched req_resp=1, else GAP. Start bits on sd_cmd_in are ignored while sending=1.
- WAIT_RESP: counter starts at 0 on entry.
  - sd_cmd_in=0 -> RX; this bit is stored as resp_data[47] and the bit count becomes 1.
  - Counter reaching NCR_MAX with no start bit -> set err_timeout, go to GAP.
  - A start bit in the same cycle the counter reaches NCR_MAX counts as a start bit, not a timeout.
- RX: shift one bit per cycle MSB-first into resp_data. After the 48th bit, go to GAP.
  - If resp_data[46]==0 and resp_data[0]==1: set resp_valid=1.
  - Otherwise: set err_format=1.
  - CRC is not checked here.
- GAP: done=1 in the first GAP cycle only. Remain for NCC_MIN cycles total, then IDLE.
  - If NCC_MIN=0, GAP lasts one cycle; done still pulses.
- Status (resp_valid, resp_data, err_*) stays stable from done until the next accept. At most one of resp_valid/err_* is set per command.
- req_valid is ignored outside IDLE. A request held during GAP is accepted on the first IDLE cycle.
- sending deasserting while in WAIT_TX_START is not an error; only the rising edge matters.
- Reset mid-command (any state): immediate return to IDLE with reset values. A partially captured response is discarded.
- Counters are wide enough for max(NCR_MAX, TX_START_MAX, NCC_MIN) and saturate; they never wrap.
- Minimum accept-to-done latency with no response: 1 (LAUNCH) + tx time + NCC gap start.

Test Plan:
- CMD0 no-response: idx=0, arg=0, resp=0; model raises sending 2 cycles after send_en for 48 cycles -> single send_en pulse, cmd_content=0x00_00000000, done 1 cycle after sending falls, no flags, req_ready high NCC_MIN=8 cycles after done.
- CMD8 with R7: idx=8, arg=0x1AA; card drives 0x08_000001AA_xx_1 with bit46=0 starting 5 cycles after tx end -> resp_valid=1, resp_data matches bit-for-bit, done pulses exactly once.
- Response timeout: resp=1, CMD line held high -> err_timeout=1 exactly NCR_MAX=64 cycles after entering WAIT_RESP, resp_valid=0.
- Format error: response with end bit 0 -> err_format=1, resp_valid=0. Repeat with transmission bit 1 -> err_format=1.
- Stuck transmitter: sending never rises -> err_tx=1 after 255 cycles, done pulses, next request is accepted normally.
- Reset mid-RX after 20 bits, then a back-to-back request held valid -> all outputs at reset values, and the new request is accepted on the first cycle after reset release.

Source files
------------

// File: rtl/sd_cmd_sequencer_if.sv
// Signal bundle between the SD command sequencer and its neighbours.
// It carries the request handshake from the init/data FSMs, the transmitter
// strobe, the busy flag and the sampled CMD line, plus the response and status outputs.
// The "master" modport is the requester/transmitter side, and "slave" is the sequencer.
interface sd_cmd_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_index;
    logic [31:0] req_arg;
    logic        req_resp;
    logic        send_en;
    logic [37:0] cmd_content;
    logic        sending;
    logic        sd_cmd_in;
    logic        done;
    logic        resp_valid;
    logic [47:0] resp_data;
    logic        err_timeout;
    logic        err_format;
    logic        err_tx;

    modport master (
        output req_valid, req_index, req_arg, req_resp, sending, sd_cmd_in,
        input  req_ready, send_en, cmd_content, done, resp_valid, resp_data,
               err_timeout, err_format, err_tx
    );

    modport slave (
        input  req_valid, req_index, req_arg, req_resp, sending, sd_cmd_in,
        output req_ready, send_en, cmd_content, done, resp_valid, resp_data,
               err_timeout, err_format, err_tx
    );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// Command-level controller for the SD CMD path.
// It takes one request at a time and strobes it into the transmitter.
// It follows the transmitter busy flag, then captures the 48-bit response,
// or it flags a tx, timeout or format error.
// After each command it holds an idle gap before it accepts the next request.
// All outputs are registered.
module sd_cmd_sequencer #(
    parameter int NCR_MAX      = 64,
    parameter int NCC_MIN      = 8,
    parameter int TX_START_MAX = 255
) (
    input logic             sd_clk,
    input logic             reset,
    sd_cmd_sequencer_if.slave bus
);

    localparam int CNT_MAX_A = (NCR_MAX > NCC_MIN) ? NCR_MAX : NCC_MIN;
    localparam int CNT_MAX   = (CNT_MAX_A > TX_START_MAX) ? CNT_MAX_A : TX_START_MAX;
    localparam int CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_TX_START,
        WAIT_TX_END,
        WAIT_RESP,
        RX,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [5:0]       bit_cnt;
    logic             resp_expected;
    logic             tx_limit;
    logic             ncr_limit;
    logic             ncc_limit;

    // The shared wait counter saturates instead of wrapping.
    // Each limit flag marks the cycle in which the count reaches its bound.
    assign cnt_inc   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign tx_limit  = (int'(cnt) + 1 >= TX_START_MAX);
    assign ncr_limit = (int'(cnt) + 1 >= NCR_MAX);
    assign ncc_limit = (int'(cnt) + 1 >= NCC_MIN);

    // This block holds the command sequencing FSM and all of its registered outputs.
    always_ff @(posedge sd_clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            bit_cnt         <= '0;
            resp_expected   <= 1'b0;
            bus.req_ready   <= 1'b1;
            bus.send_en     <= 1'b0;
            bus.cmd_content <= '0;
            bus.done        <= 1'b0;
            bus.resp_valid  <= 1'b0;
            bus.resp_data   <= '0;
            bus.err_timeout <= 1'b0;
            bus.err_format  <= 1'b0;
            bus.err_tx      <= 1'b0;
        end else begin
            bus.send_en <= 1'b0;
            bus.done    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.cmd_content <= {bus.req_index, bus.req_arg};
                        resp_expected   <= bus.req_resp;
                        bus.resp_valid  <= 1'b0;
                        bus.err_timeout <= 1'b0;
                        bus.err_format  <= 1'b0;
                        bus.err_tx      <= 1'b0;
                        bus.req_ready   <= 1'b0;
                        bus.send_en     <= 1'b1;
                        state           <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    cnt   <= '0;
                    state <= WAIT_TX_START;
                end
                WAIT_TX_START: begin
                    if (bus.sending) begin
                        cnt   <= '0;
                        state <= WAIT_TX_END;
                    end else if (tx_limit) begin
                        bus.err_tx <= 1'b1;
                        bus.done   <= 1'b1;
                        cnt        <= '0;
                        state      <= GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                WAIT_TX_END: begin
                    if (!bus.sending) begin
                        cnt <= '0;
                        if (resp_expected) begin
                            state <= WAIT_RESP;
                        end else begin
                            bus.done <= 1'b1;
                            state    <= GAP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (!bus.sd_cmd_in) begin
                        bus.resp_data[47] <= bus.sd_cmd_in;
                        bit_cnt           <= 6'd1;
                        state             <= RX;
                    end else if (ncr_limit) begin
                        bus.err_timeout <= 1'b1;
                        bus.done        <= 1'b1;
                        cnt             <= '0;
                        state           <= GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                RX: begin
                    bus.resp_data[6'd47 - bit_cnt] <= bus.sd_cmd_in;
                    if (bit_cnt == 6'd47) begin
                        if (!bus.resp_data[46] && bus.sd_cmd_in) begin
                            bus.resp_valid <= 1'b1;
                        end else begin
                            bus.err_format <= 1'b1;
                        end
                        bus.done <= 1'b1;
                        cnt      <= '0;
                        state    <= GAP;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end
                GAP: begin
                    if (ncc_limit) begin
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    bus.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer.
// Each command has a small timeline model: it gives the done and ready cycle
// numbers and the final status, counted in clock edges from the accept edge.
module tb_sd_cmd_sequencer;

    localparam int NCR_MAX      = 64;
    localparam int NCC_MIN      = 8;
    localparam int TX_START_MAX = 255;
    localparam int GAP_LEN      = (NCC_MIN < 1) ? 1 : NCC_MIN;

    localparam int K_NONE    = 0;
    localparam int K_VALID   = 1;
    localparam int K_TIMEOUT = 2;
    localparam int K_FORMAT  = 3;
    localparam int K_TX      = 4;

    logic sd_clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    sd_cmd_sequencer_if bus ();

    sd_cmd_sequencer #(
        .NCR_MAX      (NCR_MAX),
        .NCC_MIN      (NCC_MIN),
        .TX_START_MAX (TX_START_MAX)
    ) dut (
        .sd_clk (sd_clk),
        .reset  (reset),
        .bus    (bus)
    );

    // This block generates the free-running SD clock.
    always #5 sd_clk = ~sd_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " req_ready"},   64'(bus.req_ready),   64'd1);
        checkOutput({tag, " send_en"},     64'(bus.send_en),     64'd0);
        checkOutput({tag, " cmd_content"}, 64'(bus.cmd_content), 64'd0);
        checkOutput({tag, " done"},        64'(bus.done),        64'd0);
        checkOutput({tag, " resp_valid"},  64'(bus.resp_valid),  64'd0);
        checkOutput({tag, " resp_data"},   64'(bus.resp_data),   64'd0);
        checkOutput({tag, " errors"},
                    64'({bus.err_timeout, bus.err_format, bus.err_tx}), 64'd0);
    endtask

    // s: first edge with sending high; len: busy length (0 = transmitter stuck);
    // r: response start edge after tx end (0 = card silent); abort_bits>0 stops after that many bits.
    task automatic applyStimulus(input string name, input logic [5:0] idx, input logic [31:0] arg,
                                 input logic resp, input int s, input int len, input int r,
                                 input logic [47:0] bits, input int abort_bits);
        int d_exp;
        int e_end;
        int kind;
        int abort_at;
        int e;
        int send_cnt;
        int send_at;
        int done_cnt;
        int done_at;
        int ready_at;
        kind     = K_NONE;
        e_end    = s + len;
        send_cnt = 0;
        send_at  = -1;
        done_cnt = 0;
        done_at  = -1;
        ready_at = -1;
        if (len == 0) begin
            d_exp = 1 + TX_START_MAX;
            kind  = K_TX;
        end else if (!resp) begin
            d_exp = e_end;
        end else if (r >= 1 && r <= NCR_MAX) begin
            d_exp = e_end + r + 47;
            kind  = (bits[46] == 1'b0 && bits[0] == 1'b1) ? K_VALID : K_FORMAT;
        end else begin
            d_exp = e_end + NCR_MAX;
            kind  = K_TIMEOUT;
        end
        abort_at = (abort_bits > 0) ? e_end + r + abort_bits - 1 : -1;

        @(negedge sd_clk);
        checkOutput({name, " ready before accept"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_index = idx;
        bus.req_arg   = arg;
        bus.req_resp  = resp;

        for (int obs = 0; obs < 1000; obs++) begin
            @(negedge sd_clk);
            if (obs == 0) begin
                bus.req_valid = 1'b0;
                bus.req_index = 6'($urandom);
                bus.req_arg   = $urandom;
                bus.req_resp  = 1'($urandom);
            end
            if (bus.send_en) begin
                send_cnt++;
                send_at = obs;
            end
            if (bus.done) begin
                done_cnt++;
                done_at = obs;
            end
            if (bus.req_ready) begin
                ready_at = obs;
                break;
            end
            if (obs == abort_at) break;
            e = obs + 1;
            bus.sending = (len != 0) && (e >= s) && (e < e_end);
            if (bus.sending)
                bus.sd_cmd_in = 1'($urandom);
            else if (resp && r >= 1 && e >= e_end + r && e <= e_end + r + 47)
                bus.sd_cmd_in = bits[47 - (e - e_end - r)];
            else
                bus.sd_cmd_in = 1'b1;
        end
        bus.sending   = 1'b0;
        bus.sd_cmd_in = 1'b1;
        if (abort_bits > 0) return;

        checkOutput({name, " send_en pulses"}, 64'(send_cnt), 64'd1);
        checkOutput({name, " send_en cycle"},  64'(send_at),  64'd0);
        checkOutput({name, " done pulses"},    64'(done_cnt), 64'd1);
        checkOutput({name, " done cycle"},     64'(done_at),  64'(d_exp));
        checkOutput({name, " ready cycle"},    64'(ready_at), 64'(d_exp + GAP_LEN));
        checkOutput({name, " cmd_content"},    64'(bus.cmd_content), 64'({idx, arg}));
        checkOutput({name, " resp_valid"},     64'(bus.resp_valid),  64'(kind == K_VALID));
        checkOutput({name, " err_timeout"},    64'(bus.err_timeout), 64'(kind == K_TIMEOUT));
        checkOutput({name, " err_format"},     64'(bus.err_format),  64'(kind == K_FORMAT));
        checkOutput({name, " err_tx"},         64'(bus.err_tx),      64'(kind == K_TX));
        if (kind == K_VALID)
            checkOutput({name, " resp_data"}, 64'(bus.resp_data), 64'(bits));
    endtask

    initial begin
        logic [47:0] bits;
        logic [31:0] rarg;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_index = '0;
        bus.req_arg   = '0;
        bus.req_resp  = 1'b0;
        bus.sending   = 1'b0;
        bus.sd_cmd_in = 1'b1;
        repeat (3) @(negedge sd_clk);
        checkResetValues("reset");
        reset = 1'b0;

        applyStimulus("cmd0", 6'd0, 32'd0, 1'b0, 3, 48, 0, 48'd0, 0);

        bits = {2'b00, 6'd8, 32'h0000_01AA, 7'h3C, 1'b1};
        applyStimulus("cmd8", 6'd8, 32'h0000_01AA, 1'b1, 3, 48, 5, bits, 0);

        applyStimulus("timeout", 6'd55, 32'h0, 1'b1, 2, 48, 0, 48'd0, 0);

        bits = {2'b00, 6'd8, 32'h0000_01AA, 8'hAA};
        applyStimulus("fmt_end", 6'd8, 32'h0000_01AA, 1'b1, 4, 48, 3, bits, 0);

        bits = {2'b01, 6'd8, 32'h0000_01AA, 8'h55};
        applyStimulus("fmt_trans", 6'd8, 32'h0000_01AA, 1'b1, 2, 48, 64, bits, 0);

        applyStimulus("stuck_tx", 6'd2, 32'h1234_5678, 1'b0, 2, 0, 0, 48'd0, 0);
        applyStimulus("after_stuck", 6'd3, 32'hCAFE_0000, 1'b1, 2, 48, 7,
                      {2'b00, 6'd3, 32'hCAFE_0001, 8'h21}, 0);

        bits = {2'b00, 6'd17, 32'hA5A5_5A5A, 8'hFF};
        applyStimulus("abort_rx", 6'd17, 32'h0, 1'b1, 2, 48, 4, bits, 20);
        reset = 1'b1;
        #1;
        checkResetValues("mid_rx_reset");
        rarg          = $urandom;
        bus.req_valid = 1'b1;
        bus.req_index = 6'd41;
        bus.req_arg   = rarg;
        bus.req_resp  = 1'b0;
        @(negedge sd_clk);
        reset = 1'b0;
        @(negedge sd_clk);
        checkOutput("post_reset send_en",     64'(bus.send_en),     64'd1);
        checkOutput("post_reset req_ready",   64'(bus.req_ready),   64'd0);
        checkOutput("post_reset cmd_content", 64'(bus.cmd_content), 64'({6'd41, rarg}));
        bus.req_valid = 1'b0;
        reset         = 1'b1;
        @(negedge sd_clk);
        reset = 1'b0;

        for (int n = 0; n < 10; n++) begin
            logic       rresp;
            int         rs;
            int         rlen;
            int         rr;
            logic [5:0] ridx;
            ridx  = 6'($urandom);
            rarg  = $urandom;
            rresp = ($urandom_range(3, 0) != 0);
            rs    = 2 + int'($urandom_range(3, 0));
            rlen  = 38 + int'($urandom_range(11, 0));
            rr    = ($urandom_range(5, 0) == 0) ? 0 : 1 + int'($urandom_range(NCR_MAX - 1, 0));
            bits  = {16'($urandom), $urandom};
            bits[47] = 1'b0;
            bits[46] = ($urandom_range(3, 0) == 0);
            bits[0]  = ($urandom_range(3, 0) != 0);
            applyStimulus($sformatf("rand%0d", n), ridx, rarg, rresp, rs, rlen, rr, bits, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
